// File: rtl/mem_map_pkg.sv
// Address map, widths and region decode shared by the Hack data memory.
package mem_map_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 15;
  localparam int RAM_WORDS = 16384;
  localparam int SCR_WORDS = 8192;

  localparam logic [ADDR_W-1:0] RAM_BASE = 15'h0000;
  localparam logic [ADDR_W-1:0] SCR_BASE = 15'h4000;
  localparam logic [ADDR_W-1:0] KBD_ADDR = 15'h6000;

  typedef enum logic [1:0] {
    REG_RAM  = 2'd0,
    REG_SCR  = 2'd1,
    REG_KBD  = 2'd2,
    REG_NONE = 2'd3
  } region_e;

  function automatic region_e decode_region(input logic [ADDR_W-1:0] addr);
    if (!addr[14])                 return REG_RAM;
    else if (addr[14:13] == 2'b10) return REG_SCR;
    else if (addr == KBD_ADDR)     return REG_KBD;
    else                           return REG_NONE;
  endfunction

endpackage

// File: rtl/fast_ram.sv
// Word array with synchronous write and combinational read; no reset on contents.
module fast_ram #(
  parameter int DEPTH  = 16384,
  parameter int DATA_W = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[idx] <= wdata;
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/fast_memory.sv
// Hack data memory: data RAM, screen RAM and a sampled keyboard word behind one port.
module fast_memory
  import mem_map_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  output logic [DATA_W-1:0] out,
  input  logic [DATA_W-1:0] in,
  input  logic [ADDR_W-1:0] address,
  input  logic              load,
  input  logic [DATA_W-1:0] keyboard
);

  region_e           region;
  logic              ram_we;
  logic              scr_we;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] scr_rdata;
  logic [DATA_W-1:0] kbd_d;
  logic [DATA_W-1:0] kbd_q;

  assign region = decode_region(address);
  // Writes are gated by rst_n so nothing lands while reset is asserted.
  assign ram_we = load && rst_n && (region == REG_RAM);
  assign scr_we = load && rst_n && (region == REG_SCR);

  fast_ram #(.DEPTH(RAM_WORDS), .DATA_W(DATA_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .idx   (address[13:0]),
    .wdata (in),
    .rdata (ram_rdata)
  );

  fast_ram #(.DEPTH(SCR_WORDS), .DATA_W(DATA_W)) u_scr (
    .clk   (clk),
    .we    (scr_we),
    .idx   (address[12:0]),
    .wdata (in),
    .rdata (scr_rdata)
  );

  always_comb begin
    kbd_d = keyboard;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kbd_q <= '0;
    else        kbd_q <= kbd_d;
  end

  always_comb begin
    out = '0;
    case (region)
      REG_RAM:  out = ram_rdata;
      REG_SCR:  out = scr_rdata;
      REG_KBD:  out = kbd_q;
      default:  out = '0;
    endcase
  end

endmodule

// File: tb/tb_fast_memory.sv
// Scoreboard bench for fast_memory: expected read words queued at stimulus, popped at readback.
module tb_fast_memory;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] out;
  logic [15:0] in = '0;
  logic [14:0] address = '0;
  logic        load = 1'b0;
  logic [15:0] keyboard = '0;

  int checks = 0;
  int failures = 0;
  logic [15:0] sb [$];
  logic [15:0] exp_v;

  fast_memory dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .out      (out),
    .in       (in),
    .address  (address),
    .load     (load),
    .keyboard (keyboard)
  );

  always #5 clk = ~clk;

  // One write cycle: drive after negedge, let one rising edge capture it.
  task automatic do_write(input logic [14:0] a, input logic [15:0] d);
    @(negedge clk);
    address = a; in = d; load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    keyboard = 16'h0041;
    address = 15'h6000;
    sb.push_back(16'h0000);
    #1; exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL reset_kbd got=%h exp=%h", out, exp_v); end
    else $display("reset_kbd addr=6000 out=%h", out);
    address = 15'h7FFF;
    sb.push_back(16'h0000);
    #1; exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL reset_unmapped got=%h exp=%h", out, exp_v); end
    else $display("reset_unmapped addr=7fff out=%h", out);
    keyboard = 16'h0000;
    @(negedge clk); #2; rst_n = 1'b1;
  endtask

  task automatic test_ram_write();
    do_write(15'h0000, 16'hABAB);
    sb.push_back(16'hABAB);
    @(negedge clk);
    address = 15'h0000; in = 16'hCDCD; load = 1'b0;
    #1; exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL ram_write got=%h exp=%h", out, exp_v); end
    else $display("ram_write addr=0000 out=%h", out);
  endtask

  task automatic test_no_spurious();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      address = 15'h0000; in = 16'hCDCD; load = 1'b0;
      sb.push_back(16'hABAB);
      @(posedge clk); #1;
      exp_v = sb.pop_front(); checks++;
      if (out !== exp_v) begin failures++; $display("FAIL no_spurious[%0d] got=%h exp=%h", i, out, exp_v); end
      else $display("no_spurious[%0d] addr=0000 out=%h", i, out);
    end
  endtask

  task automatic test_kbd();
    @(negedge clk);
    keyboard = 16'h0041;
    do_write(15'h6000, 16'hABAB);
    sb.push_back(16'h0041);
    address = 15'h6000;
    #1; exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL kbd_read got=%h exp=%h", out, exp_v); end
    else $display("kbd_read addr=6000 out=%h", out);
    // New key code is not visible until the next rising edge samples it.
    @(negedge clk);
    keyboard = 16'h0042;
    sb.push_back(16'h0041);
    #1; exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL kbd_pre_edge got=%h exp=%h", out, exp_v); end
    else $display("kbd_pre_edge addr=6000 out=%h", out);
    sb.push_back(16'h0042);
    @(posedge clk); #1;
    exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL kbd_post_edge got=%h exp=%h", out, exp_v); end
    else $display("kbd_post_edge addr=6000 out=%h", out);
  endtask

  task automatic test_unmapped();
    do_write(15'h6001, 16'hABAB);
    sb.push_back(16'h0000);
    address = 15'h6001;
    #1; exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", out, exp_v); end
    else $display("unmapped_read addr=6001 out=%h", out);
    sb.push_back(16'hABAB);
    address = 15'h0000;
    #1; exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL unmapped_ram_intact got=%h exp=%h", out, exp_v); end
    else $display("unmapped_ram_intact addr=0000 out=%h", out);
  endtask

  task automatic test_boundaries();
    logic [14:0] addrs [3];
    logic [15:0] vals  [3];
    addrs[0] = 15'h4000; vals[0] = 16'h1234;
    addrs[1] = 15'h5FFF; vals[1] = 16'h1234;
    addrs[2] = 15'h3FFF; vals[2] = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      do_write(addrs[i], vals[i]);
      sb.push_back(vals[i]);
    end
    for (int i = 0; i < 3; i++) begin
      address = addrs[i];
      #1; exp_v = sb.pop_front(); checks++;
      if (out !== exp_v) begin failures++; $display("FAIL boundary addr=%h got=%h exp=%h", addrs[i], out, exp_v); end
      else $display("boundary addr=%h out=%h", addrs[i], out);
    end
    // 0x4000 aliases nothing in data RAM: 0x0000 must still hold its own word.
    address = 15'h0000;
    sb.push_back(16'hABAB);
    #1; exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL boundary_alias got=%h exp=%h", out, exp_v); end
    else $display("boundary_alias addr=0000 out=%h", out);
  endtask

  task automatic test_rdw();
    @(negedge clk);
    address = 15'h0010; in = 16'h0F0F; load = 1'b1;
    @(posedge clk); #1;
    in = 16'hF0F0;
    sb.push_back(16'h0F0F);
    #1; exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL rdw_old got=%h exp=%h", out, exp_v); end
    else $display("rdw_old addr=0010 out=%h", out);
    sb.push_back(16'hF0F0);
    @(posedge clk); #1;
    load = 1'b0;
    exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL rdw_new got=%h exp=%h", out, exp_v); end
    else $display("rdw_new addr=0010 out=%h", out);
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    load = 1'b1;
    for (int i = 0; i < 8; i++) begin
      address = 15'h0100 + 15'(i);
      in = 16'hA500 ^ 16'(i * 16'h0111);
      sb.push_back(in);
      @(negedge clk);
    end
    load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      address = 15'h0100 + 15'(i);
      #1; exp_v = sb.pop_front(); checks++;
      if (out !== exp_v) begin failures++; $display("FAIL b2b addr=%h got=%h exp=%h", address, out, exp_v); end
      else $display("b2b addr=%h out=%h", address, out);
    end
  endtask

  task automatic test_reset_pulse();
    @(negedge clk);
    keyboard = 16'h0041;
    address = 15'h0000; in = 16'h1111; load = 1'b1;
    #2; rst_n = 1'b0;
    address = 15'h6000;
    sb.push_back(16'h0000);
    #1; exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL rstpulse_kbd got=%h exp=%h", out, exp_v); end
    else $display("rstpulse_kbd addr=6000 out=%h", out);
    address = 15'h0000;
    @(posedge clk); #1;
    sb.push_back(16'hABAB);
    exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL rstpulse_ram got=%h exp=%h", out, exp_v); end
    else $display("rstpulse_ram addr=0000 out=%h", out);
    // Release mid-cycle with load still high: next rising edge performs the write.
    @(negedge clk); #2;
    rst_n = 1'b1;
    address = 15'h0001; in = 16'h2222;
    @(posedge clk); #1;
    load = 1'b0;
    sb.push_back(16'h2222);
    exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL rstrel_write got=%h exp=%h", out, exp_v); end
    else $display("rstrel_write addr=0001 out=%h", out);
    address = 15'h0000;
    sb.push_back(16'hABAB);
    #1; exp_v = sb.pop_front(); checks++;
    if (out !== exp_v) begin failures++; $display("FAIL rstrel_ram got=%h exp=%h", out, exp_v); end
    else $display("rstrel_ram addr=0000 out=%h", out);
  endtask

  initial begin
    test_reset();
    test_ram_write();
    test_no_spurious();
    test_kbd();
    test_unmapped();
    test_boundaries();
    test_rdw();
    test_back_to_back();
    test_reset_pulse();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
